debug_regs_ctrl: RTL

DEBUG_REGS_CTRL -- requirements
Module: debug_regs_ctrl

---
 rtl/debug_regs_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/debug_regs_ctrl.sv
// Debug register-file access controller: halts the core, owns the RF port, performs one access per request.
// Access latency: ack in the third cycle counting the HALTED cycle that samples dbg_req; plus halt wait from IDLE.
module debug_regs_ctrl #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int HALT_TMO = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dbg_halt,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [REG_AW-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic              dbg_err,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              halt_req,
    input  logic              core_halted,
    output logic              halted_ind,
    output logic              rf_sel,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [REG_AW-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata
);

    localparam int CNT_W = (HALT_TMO < 1) ? 1 : $clog2(HALT_TMO + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HALT_WAIT = 3'd1,
        HALTED    = 3'd2,
        ACCESS    = 3'd3,
        RESP      = 3'd4,
        DROP      = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             tmo_hit;
    logic             err_nxt;
    logic             own_nxt;
    logic             latch;
    logic             acc_we;

    assign tmo_hit = (cnt == CNT_W'(HALT_TMO));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (dbg_halt || dbg_req) begin
                    state_nxt = HALT_WAIT;
                    cnt_nxt   = '0;
                end
            end
            HALT_WAIT: begin
                // Counter saturates at the timeout value
                if (!tmo_hit) cnt_nxt = cnt + 1'b1;
                if (core_halted) begin
                    state_nxt = HALTED;
                end else if (tmo_hit) begin
                    state_nxt = RESP;
                    err_nxt   = 1'b1;
                end else if (!dbg_req && !dbg_halt) begin
                    state_nxt = IDLE;
                end
            end
            HALTED: begin
                if (dbg_req) begin
                    state_nxt = ACCESS;
                    latch     = 1'b1;
                end else if (!dbg_halt) begin
                    state_nxt = IDLE;
                end
            end
            ACCESS: state_nxt = RESP;
            RESP:   state_nxt = dbg_err ? IDLE : DROP;
            DROP: begin
                if (!dbg_req) state_nxt = HALTED;
            end
            default: state_nxt = IDLE;
        endcase
        // Ownership is held through a normal response, but not through a timeout response
        own_nxt = (state_nxt == HALTED) || (state_nxt == ACCESS) || (state_nxt == DROP) ||
                  ((state_nxt == RESP) && !err_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            acc_we     <= 1'b0;
            halt_req   <= 1'b0;
            rf_sel     <= 1'b0;
            halted_ind <= 1'b0;
            dbg_ack    <= 1'b0;
            dbg_err    <= 1'b0;
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            rf_raddr   <= '0;
            dbg_rdata  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            halt_req   <= (state_nxt != IDLE);
            rf_sel     <= own_nxt;
            halted_ind <= own_nxt;
            dbg_ack    <= (state_nxt == RESP);
            dbg_err    <= err_nxt;
            // Writes to index 0 complete normally but never strobe the register file
            rf_we      <= latch && dbg_we && (dbg_addr != '0);
            if (latch) begin
                acc_we   <= dbg_we;
                rf_waddr <= dbg_addr;
                rf_wdata <= dbg_wdata;
                rf_raddr <= dbg_addr;
            end
            if ((state == ACCESS) && !acc_we) dbg_rdata <= rf_rdata;
        end
    end

endmodule
